uc_booth: RTL and testbench
===========================

Name: uc_booth

Overview:
- Control unit (Moore FSM plus iteration counter) that sequences the radix-2 Booth multiplier datapath: registers A, Q and M, the Q-1 flip-flop, and the add/subtract unit.
- Accepts a level start request and drives the datapath load, add/subtract and arithmetic-shift controls for N iterations.
- Raises fin when the product is valid on the datapath's resultado bus.
- Sits beside camino_datos in the multiplier top, which wires the two together.

Parameters:
- N, 3, operand width in bits and number of Booth iterations (shifts).
- CW, 2, counter width; must satisfy 2**CW >= N.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears FSM and counter immediately.
- inicio  input  1  start request (level); sampled only in state IDLE.
- q0  input  1  LSB of register Q (datapath salida_q[0]).
- qsub1  input  1  Q-1 bit from the datapath.
- CargaA  output  1  load A from the adder/subtractor output.
- CargaQ  output  1  load Q from entrada_q.
- CargaM  output  1  load M from entrada_m (sign-extended by the datapath).
- desplaza  output  1  arithmetic right shift of A:Q; the top level also ties the Q-1 flip-flop load to this signal.
- resta  output  1  selects A-M (1) or A+M (0) at the adder.
- limpia  output  1  clear pulse; the top level uses it to zero A and Q-1 before an operation.
- ocupado  output  1  high in every state except IDLE and FIN.
- fin  output  1  product valid.

Behaviour:
- States: IDLE, CARGA, EXAMINA, SUMA, RESTA, DESPLAZA, FIN. State codes are 3-bit, binary, IDLE=0.
- All outputs are decoded from the state only (Moore). There are no registered outputs besides the state and counter.
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, every output 0. This holds mid-operation; datapath contents are then don't-care.
- IDLE:
  - All outputs 0.
  - inicio=1 -> CARGA; otherwise stay.
- CARGA:
  - Outputs: CargaQ=1, CargaM=1, limpia=1, ocupado=1; cnt<=0.
  - Next state: EXAMINA (unconditional).
- EXAMINA: ocupado=1. Next state by {q0,qsub1}:
  - 10 -> RESTA
  - 01 -> SUMA
  - 00 or 11 -> DESPLAZA
- SUMA:
  - Outputs: CargaA=1, resta=0, ocupado=1.
  - Next state: DESPLAZA.
- RESTA:
  - Outputs: CargaA=1, resta=1, ocupado=1.
  - Next state: DESPLAZA.
- DESPLAZA:
  - Outputs: desplaza=1, ocupado=1.
  - If cnt==N-1 -> FIN, cnt holds. Otherwise cnt<=cnt+1 and go to EXAMINA.
- FIN:
  - Outputs: fin=1.
  - inicio=0 -> IDLE; inicio=1 -> stay in FIN.
  - A held inicio therefore never retriggers; a new operation needs inicio low for at least one cycle, then high.
- q0 and qsub1 are used only in EXAMINA. They are stable in SUMA/RESTA because Q and Q-1 change only on load or shift.
- resta=0 and CargaA=0 in every state other than SUMA/RESTA.
- CargaA, CargaQ/CargaM and desplaza are mutually exclusive in every state.
- inicio dropping during an operation is ignored; the operation completes. fin is then high for exactly one cycle.
- Latency, counted from the edge that samples inicio=1 in IDLE:
  - The state is FIN after 1 + 2N + k edges, where k = number of iterations needing add/sub.
  - N=3: minimum 7 edges, maximum 10 edges.
- The counter never wraps: it only increments while cnt < N-1.

Decomposition:
- Shared header uc_booth_defs.vh: state codes (IDLE..FIN) and the default N/CW. The datapath top includes it for bench monitoring.
- One natural sub-module: contador_iter. It is a CW-bit counter with synchronous clear and enable, async active-low reset, and a terminal flag (cnt==N-1). The FSM drives clear in CARGA and enable in non-terminal DESPLAZA.

Test Plan:
- Reset: assert reset=0 mid-SUMA with inicio=1 -> state IDLE and all outputs 0 without waiting for a clock edge; after release with inicio=1, CARGA on the next edge.
- Controller alone, q0/qsub1 forced 00 every EXAMINA -> sequence CARGA, (EXAMINA, DESPLAZA)x3, FIN. fin high after edge 7, desplaza pulsed exactly 3 times, CargaA never asserted.
- Integrated with camino_datos, entrada_m=011, entrada_q=010 (3x2):
  - Sequence: EXAMINA->DESPLAZA, EXAMINA->RESTA->DESPLAZA, EXAMINA->SUMA->DESPLAZA.
  - fin after edge 9; resultado=6'b000110.
- Integrated, entrada_m=101 (-3), entrada_q=010 -> resultado=6'b111010 (-6); resta=1 during exactly one cycle.
- Integrated, entrada_m=011, entrada_q=101 (3x-3):
  - Every iteration takes the add/sub path.
  - fin after edge 10; resultado=6'b110111 (-9).
- Handshake:
  - Case 1: hold inicio=1 through FIN for 5 cycles -> fin stays 1 and no new CARGA. Drop inicio -> IDLE next edge; raise it -> CARGA.
  - Case 2: drop inicio during EXAMINA -> operation completes and fin is high for exactly 1 cycle.

Source files
------------

// File: rtl/uc_booth_pkg.sv
// rtl/uc_booth_pkg.sv - shared state codes, defaults and output decode for the Booth control unit
package uc_booth_pkg;

    localparam int N_DEF  = 3;
    localparam int CW_DEF = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CARGA    = 3'd1;
    localparam logic [2:0] S_EXAMINA  = 3'd2;
    localparam logic [2:0] S_SUMA     = 3'd3;
    localparam logic [2:0] S_RESTA    = 3'd4;
    localparam logic [2:0] S_DESPLAZA = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    typedef struct packed {
        logic carga_a;
        logic carga_q;
        logic carga_m;
        logic desplaza;
        logic resta;
        logic limpia;
        logic ocupado;
        logic fin;
    } ctrl_t;

    // Moore decode: every control line is a pure function of the state code
    function automatic ctrl_t decode_ctrl(input logic [2:0] st);
        ctrl_t c;
        c = '0;
        case (st)
            S_CARGA: begin
                c.carga_q = 1'b1;
                c.carga_m = 1'b1;
                c.limpia  = 1'b1;
                c.ocupado = 1'b1;
            end
            S_EXAMINA: c.ocupado = 1'b1;
            S_SUMA: begin
                c.carga_a = 1'b1;
                c.ocupado = 1'b1;
            end
            S_RESTA: begin
                c.carga_a = 1'b1;
                c.resta   = 1'b1;
                c.ocupado = 1'b1;
            end
            S_DESPLAZA: begin
                c.desplaza = 1'b1;
                c.ocupado  = 1'b1;
            end
            S_FIN:   c.fin = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uc_booth_contador_iter.sv
// rtl/uc_booth_contador_iter.sv - Booth iteration counter with clear, enable and terminal flag
module uc_booth_contador_iter #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == CW'(N - 1));

endmodule

// File: rtl/uc_booth.sv
// rtl/uc_booth.sv - Moore control unit sequencing the radix-2 Booth multiplier datapath
module uc_booth
    import uc_booth_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic q0,
    input  logic qsub1,
    output logic CargaA,
    output logic CargaQ,
    output logic CargaM,
    output logic desplaza,
    output logic resta,
    output logic limpia,
    output logic ocupado,
    output logic fin
);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       term;
    ctrl_t      ctrl;

    // Counter only advances on non-terminal shifts, so it never wraps
    uc_booth_contador_iter #(
        .N  (N),
        .CW (CW)
    ) u_contador (
        .clk   (clk),
        .rst_n (reset),
        .clr   (state == S_CARGA),
        .en    ((state == S_DESPLAZA) && !term),
        .term  (term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (inicio) state_nx = S_CARGA;
            S_CARGA:   state_nx = S_EXAMINA;
            S_EXAMINA: begin
                case ({q0, qsub1})
                    2'b10:   state_nx = S_RESTA;
                    2'b01:   state_nx = S_SUMA;
                    default: state_nx = S_DESPLAZA;
                endcase
            end
            S_SUMA:     state_nx = S_DESPLAZA;
            S_RESTA:    state_nx = S_DESPLAZA;
            S_DESPLAZA: state_nx = term ? S_FIN : S_EXAMINA;
            // A held inicio parks here; a fresh request needs a low cycle first
            S_FIN:      if (!inicio) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    assign ctrl     = decode_ctrl(state);
    assign CargaA   = ctrl.carga_a;
    assign CargaQ   = ctrl.carga_q;
    assign CargaM   = ctrl.carga_m;
    assign desplaza = ctrl.desplaza;
    assign resta    = ctrl.resta;
    assign limpia   = ctrl.limpia;
    assign ocupado  = ctrl.ocupado;
    assign fin      = ctrl.fin;

endmodule

// File: tb/tb_uc_booth.sv
// tb/tb_uc_booth.sv - scoreboard bench for uc_booth driving a behavioural Booth datapath
module tb_uc_booth;

    localparam int N  = 3;
    localparam int CW = 2;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic inicio = 1'b0;
    logic q0, qsub1;
    logic CargaA, CargaQ, CargaM, desplaza, resta, limpia, ocupado, fin;

    uc_booth #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .q0       (q0),
        .qsub1    (qsub1),
        .CargaA   (CargaA),
        .CargaQ   (CargaQ),
        .CargaM   (CargaM),
        .desplaza (desplaza),
        .resta    (resta),
        .limpia   (limpia),
        .ocupado  (ocupado),
        .fin      (fin)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int unsigned edge_cnt = 0;

    // Behavioural datapath: A (one guard bit), Q, M, Q-1
    logic signed [N:0] a_r  = '0;
    logic signed [N:0] m_r  = '0;
    logic [N-1:0]      q_r  = '0;
    logic              q1_r = 1'b0;
    logic [N-1:0]      ent_m = '0;
    logic [N-1:0]      ent_q = '0;
    logic [2*N-1:0]    resultado;

    assign q0        = q_r[0];
    assign qsub1     = q1_r;
    assign resultado = {a_r[N-1:0], q_r};

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (limpia) begin
            a_r  <= '0;
            q1_r <= 1'b0;
        end
        if (CargaQ) q_r <= ent_q;
        if (CargaM) m_r <= {ent_m[N-1], ent_m};
        if (CargaA) a_r <= resta ? a_r - m_r : a_r + m_r;
        if (desplaza) begin
            a_r  <= a_r >>> 1;
            q_r  <= {a_r[0], q_r[N-1:1]};
            q1_r <= q_r[0];
        end
    end

    typedef struct {
        logic [2*N-1:0] prod;
        int             lat;
        int             n_add;
        int             n_sub;
        int unsigned    start;
    } exp_t;

    exp_t sb[$];

    // Reference: signed product, and Booth pair counts taken straight from the multiplier bits
    function automatic exp_t ref_model(input logic [N-1:0] m, input logic [N-1:0] q,
                                       input int unsigned start);
        exp_t r;
        int   mi, qi;
        logic prev;
        mi      = $signed(m);
        qi      = $signed(q);
        prev    = 1'b0;
        r.n_add = 0;
        r.n_sub = 0;
        for (int i = 0; i < N; i++) begin
            if (q[i] && !prev) r.n_sub++;
            if (!q[i] && prev) r.n_add++;
            prev = q[i];
        end
        r.prod  = (2*N)'(mi * qi);
        r.lat   = 1 + 2*N + r.n_add + r.n_sub;
        r.start = start;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: timed out at t=%0t", name, $time);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each rising fin
    int   n_shift = 0, n_add = 0, n_sub = 0;
    logic fin_d = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            check("excl", int'((int'(CargaA) + int'(CargaQ) + int'(desplaza)) > 1), 0);
            check("resta_only_with_carga_a", int'(resta && !CargaA), 0);
            check("carga_q_eq_carga_m", int'(CargaQ), int'(CargaM));
            if (CargaQ) begin
                n_shift = 0;
                n_add   = 0;
                n_sub   = 0;
            end
            if (desplaza) n_shift++;
            if (CargaA) begin
                if (resta) n_sub++;
                else       n_add++;
            end
            if (fin && !fin_d) begin
                if (sb.size() == 0) begin
                    timeout("sb_unexpected_fin");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resultado", int'(resultado), int'(e.prod));
                    check("latency", int'(edge_cnt - e.start), e.lat);
                    check("n_desplaza", n_shift, N);
                    check("n_suma", n_add, e.n_add);
                    check("n_resta", n_sub, e.n_sub);
                end
            end
            fin_d = fin;
        end else begin
            fin_d = 1'b0;
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while ((ocupado || fin) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (ocupado || fin) timeout("wait_idle");
    endtask

    task automatic wait_fin(output bit seen);
        int t;
        t = 0;
        while (!fin && t < 30) begin
            @(negedge clk);
            t++;
        end
        seen = fin;
        if (!seen) timeout("wait_fin");
    endtask

    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input bit hold);
        bit seen;
        wait_idle();
        ent_m  = m;
        ent_q  = q;
        inicio = 1'b1;
        sb.push_back(ref_model(m, q, edge_cnt + 1));
        if (!hold) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            inicio = 1'b0;
        end
        wait_fin(seen);
        if (seen && !hold) begin
            @(negedge clk);
            check("fin_one_cycle", int'(fin), 0);
        end else if (seen) begin
            repeat (5) begin
                @(negedge clk);
                check("fin_held", int'(fin), 1);
                check("no_recarga", int'(CargaQ), 0);
            end
            inicio = 1'b0;
            @(negedge clk);
            check("idle_after_drop", int'({fin, ocupado}), 0);
            inicio = 1'b1;
            sb.push_back(ref_model(m, q, edge_cnt + 1));
            @(negedge clk);
            check("recarga", int'(CargaQ), 1);
            inicio = 1'b0;
            wait_fin(seen);
        end
    endtask

    initial begin
        bit seen;
        int t;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({CargaA, CargaQ, CargaM, desplaza, resta, limpia, ocupado, fin}), 0);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'b011, 3'b010, 1'b0);
        run_op(3'b101, 3'b010, 1'b0);
        run_op(3'b011, 3'b101, 1'b0);
        run_op(3'b011, 3'b000, 1'b0);
        run_op(3'b100, 3'b100, 1'b0);
        run_op(3'($urandom), 3'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_op(3'($urandom), 3'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of SUMA, inicio held high throughout
        wait_idle();
        ent_m  = 3'b011;
        ent_q  = 3'b010;
        inicio = 1'b1;
        sb.push_back(ref_model(ent_m, ent_q, edge_cnt + 1));
        t = 0;
        while (!(CargaA && !resta) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!(CargaA && !resta)) timeout("reach_suma");
        #2 reset = 1'b0;
        #1 check("async_reset_outputs",
                 int'({CargaA, CargaQ, CargaM, desplaza, resta, limpia, ocupado, fin}), 0);
        sb.delete();
        @(negedge clk);
        check("reset_hold_outputs",
              int'({CargaA, CargaQ, CargaM, desplaza, resta, limpia, ocupado, fin}), 0);
        reset = 1'b1;
        sb.push_back(ref_model(ent_m, ent_q, edge_cnt + 1));
        @(negedge clk);
        check("carga_after_reset", int'(CargaQ), 1);
        inicio = 1'b0;
        wait_fin(seen);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
